// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, R-type funct codes,
// ALU operation codes and branch-type codes.
package decode_pkg;

  // Primary opcodes, IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BGT   = 6'd7;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  // R-type funct codes, IR[5:0]
  localparam logic [5:0] FN_SLL = 6'd0;
  localparam logic [5:0] FN_SRL = 6'd2;
  localparam logic [5:0] FN_SRA = 6'd3;
  localparam logic [5:0] FN_MUL = 6'd24;
  localparam logic [5:0] FN_DIV = 6'd26;
  localparam logic [5:0] FN_ADD = 6'd32;
  localparam logic [5:0] FN_SUB = 6'd34;
  localparam logic [5:0] FN_AND = 6'd36;
  localparam logic [5:0] FN_OR  = 6'd37;
  localparam logic [5:0] FN_XOR = 6'd38;
  localparam logic [5:0] FN_NOR = 6'd39;
  localparam logic [5:0] FN_SLT = 6'd42;

  // ALU operation codes driven on dx_aluctr
  localparam logic [3:0] ALUCTR_ADD = 4'd0;
  localparam logic [3:0] ALUCTR_SUB = 4'd1;
  localparam logic [3:0] ALUCTR_SLT = 4'd2;
  localparam logic [3:0] ALUCTR_MUL = 4'd3;
  localparam logic [3:0] ALUCTR_DIV = 4'd4;
  localparam logic [3:0] ALUCTR_AND = 4'd5;
  localparam logic [3:0] ALUCTR_OR  = 4'd6;
  localparam logic [3:0] ALUCTR_XOR = 4'd7;
  localparam logic [3:0] ALUCTR_NOR = 4'd8;
  localparam logic [3:0] ALUCTR_SLL = 4'd9;
  localparam logic [3:0] ALUCTR_SRL = 4'd10;
  localparam logic [3:0] ALUCTR_SRA = 4'd11;

  // Branch types driven on dx_br
  localparam logic [1:0] BR_NONE = 2'd0;
  localparam logic [1:0] BR_EQ   = 2'd1;
  localparam logic [1:0] BR_NE   = 2'd2;
  localparam logic [1:0] BR_GT   = 2'd3;

endpackage

// File: rtl/decode_regfile.sv
// Register file for the decode stage: one write port shared between
// write-back (running) and host load (frozen), two bypassed read ports
// for rs/rt, and NDBG registered debug read ports.
module decode_regfile
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NDBG = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 wb_we,
  input  logic [AW-1:0]        wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 host_we,
  input  logic [AW-1:0]        host_idx,
  input  logic [XLEN-1:0]      host_data,
  input  logic [AW-1:0]        rs_idx,
  input  logic [AW-1:0]        rt_idx,
  output logic [XLEN-1:0]      rs_data,
  output logic [XLEN-1:0]      rt_data,
  input  logic [NDBG*AW-1:0]   dbg_sel,
  output logic [NDBG*XLEN-1:0] dbg_data
);

  logic [XLEN-1:0] regs_q [NREG];
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_data;

  // Write arbitration: write-back owns the port while running, the host
  // while frozen. Register 0 is never written.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = wb_rd;
    wr_data = wb_data;
    if (en) begin
      wr_en = wb_we && (wb_rd != '0);
    end else begin
      wr_idx  = host_idx;
      wr_data = host_data;
      wr_en   = host_we && (host_idx != '0);
    end
  end

  // Read with same-cycle bypass of the accepted write; r0 reads zero.
  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] idx);
    if (idx == '0)
      return '0;
    else if (wr_en && (wr_idx == idx))
      return wr_data;
    else
      return regs_q[idx];
  endfunction

  // Storage update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Operand read ports
  always_comb begin
    rs_data = read_port(rs_idx);
    rt_data = read_port(rt_idx);
  end

  // Debug ports sample while running and hold while frozen
  for (genvar k = 0; k < NDBG; k++) begin : g_dbg
    logic [XLEN-1:0] dbg_q;
    always_ff @(posedge clk) begin
      if (rst)
        dbg_q <= '0;
      else if (en)
        dbg_q <= read_port(dbg_sel[k*AW +: AW]);
    end
    assign dbg_data[k*XLEN +: XLEN] = dbg_q;
  end

endmodule

// File: rtl/decode_stage_p.sv
// Instruction-decode stage: decodes fd_ir, reads operands from the register
// file, detects load-use hazards and loads the ID/EX (DX) pipeline register.
//
// Handshake: an instruction on fd_* is consumed at a rising edge when
// en=1, fd_valid=1, flush=0 and stall=0; while stall=1 fetch must keep
// fd_* unchanged and the stage inserts a bubble. flush squashes fd_* and
// also inserts a bubble.
module decode_stage_p
  import decode_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NDBG = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           fd_valid,
  input  logic [31:0]                    fd_ir,
  input  logic [XLEN-1:0]                fd_pc,
  input  logic                           flush,
  input  logic                           wb_we,
  input  logic [$clog2(NREG)-1:0]        wb_rd,
  input  logic [XLEN-1:0]                wb_data,
  input  logic                           host_we,
  input  logic [$clog2(NREG)-1:0]        host_idx,
  input  logic [XLEN-1:0]                host_data,
  input  logic [NDBG*$clog2(NREG)-1:0]   dbg_sel,
  output logic [NDBG*XLEN-1:0]           dbg_data,
  output logic                           stall,
  output logic                           dx_valid,
  output logic [XLEN-1:0]                dx_a,
  output logic [XLEN-1:0]                dx_b,
  output logic [XLEN-1:0]                dx_rt,
  output logic [XLEN-1:0]                dx_pc,
  output logic [$clog2(NREG)-1:0]        dx_rd,
  output logic [3:0]                     dx_aluctr,
  output logic [4:0]                     dx_shamt,
  output logic                           dx_memtoreg,
  output logic                           dx_memwrite,
  output logic                           dx_jump,
  output logic [1:0]                     dx_br,
  output logic [XLEN-1:0]                dx_offset,
  output logic [27:0]                    dx_addr,
  output logic                           dx_illegal
);

  localparam int AW = $clog2(NREG);

  logic [5:0]      opcode, funct;
  logic [AW-1:0]   rs_idx, rt_idx, rdf_idx;
  logic [XLEN-1:0] rs_val, rt_val, imm_sext;

  logic [3:0]      dec_aluctr;
  logic [AW-1:0]   dec_rd;
  logic            dec_memtoreg, dec_memwrite, dec_jump, dec_use_imm;
  logic            dec_reads_rt, dec_illegal;
  logic [1:0]      dec_br;

  logic            dx_valid_q, dx_valid_d;
  logic [XLEN-1:0] dx_a_q, dx_a_d, dx_b_q, dx_b_d, dx_rt_q, dx_rt_d;
  logic [XLEN-1:0] dx_pc_q, dx_pc_d, dx_offset_q, dx_offset_d;
  logic [AW-1:0]   dx_rd_q, dx_rd_d;
  logic [3:0]      dx_aluctr_q, dx_aluctr_d;
  logic [4:0]      dx_shamt_q, dx_shamt_d;
  logic            dx_memtoreg_q, dx_memtoreg_d, dx_memwrite_q, dx_memwrite_d;
  logic            dx_jump_q, dx_jump_d, dx_illegal_q, dx_illegal_d;
  logic [1:0]      dx_br_q, dx_br_d;
  logic [27:0]     dx_addr_q, dx_addr_d;

  assign opcode   = fd_ir[31:26];
  assign funct    = fd_ir[5:0];
  assign rs_idx   = fd_ir[21 +: AW];
  assign rt_idx   = fd_ir[16 +: AW];
  assign rdf_idx  = fd_ir[11 +: AW];
  assign imm_sext = {{(XLEN-16){fd_ir[15]}}, fd_ir[15:0]};

  decode_regfile #(.XLEN(XLEN), .NREG(NREG), .NDBG(NDBG), .AW(AW)) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .host_we   (host_we),
    .host_idx  (host_idx),
    .host_data (host_data),
    .rs_idx    (rs_idx),
    .rt_idx    (rt_idx),
    .rs_data   (rs_val),
    .rt_data   (rt_val),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  // Instruction decoder; illegal encodings lose every side effect
  always_comb begin
    dec_aluctr   = ALUCTR_ADD;
    dec_rd       = '0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_jump     = 1'b0;
    dec_br       = BR_NONE;
    dec_use_imm  = 1'b0;
    dec_reads_rt = 1'b0;
    dec_illegal  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_reads_rt = 1'b1;
        dec_rd       = rdf_idx;
        case (funct)
          FN_ADD:  dec_aluctr = ALUCTR_ADD;
          FN_SUB:  dec_aluctr = ALUCTR_SUB;
          FN_SLT:  dec_aluctr = ALUCTR_SLT;
          FN_MUL:  dec_aluctr = ALUCTR_MUL;
          FN_DIV:  dec_aluctr = ALUCTR_DIV;
          FN_AND:  dec_aluctr = ALUCTR_AND;
          FN_OR:   dec_aluctr = ALUCTR_OR;
          FN_XOR:  dec_aluctr = ALUCTR_XOR;
          FN_NOR:  dec_aluctr = ALUCTR_NOR;
          FN_SLL:  dec_aluctr = ALUCTR_SLL;
          FN_SRL:  dec_aluctr = ALUCTR_SRL;
          FN_SRA:  dec_aluctr = ALUCTR_SRA;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        dec_use_imm  = 1'b1;
        dec_memtoreg = 1'b1;
        dec_rd       = rt_idx;
      end
      OP_SW: begin
        dec_use_imm  = 1'b1;
        dec_memwrite = 1'b1;
        dec_reads_rt = 1'b1;
      end
      OP_BEQ: begin
        dec_aluctr   = ALUCTR_SUB;
        dec_br       = BR_EQ;
        dec_reads_rt = 1'b1;
      end
      OP_BNE: begin
        dec_aluctr   = ALUCTR_SUB;
        dec_br       = BR_NE;
        dec_reads_rt = 1'b1;
      end
      OP_BGT: begin
        dec_aluctr   = ALUCTR_SUB;
        dec_br       = BR_GT;
        dec_reads_rt = 1'b1;
      end
      OP_J:    dec_jump = 1'b1;
      OP_ADDI: begin
        dec_use_imm = 1'b1;
        dec_rd      = rt_idx;
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_rd       = '0;
      dec_memtoreg = 1'b0;
      dec_memwrite = 1'b0;
      dec_jump     = 1'b0;
      dec_br       = BR_NONE;
    end
  end

  // Load-use hazard against the load currently sitting in DX
  assign stall = fd_valid && dx_valid_q && dx_memtoreg_q && (dx_rd_q != '0) &&
                 ((dx_rd_q == rs_idx) || ((dx_rd_q == rt_idx) && dec_reads_rt));

  // DX next state: hold when frozen, bubble on flush/stall/no input, else load
  always_comb begin
    dx_valid_d    = dx_valid_q;
    dx_a_d        = dx_a_q;
    dx_b_d        = dx_b_q;
    dx_rt_d       = dx_rt_q;
    dx_pc_d       = dx_pc_q;
    dx_rd_d       = dx_rd_q;
    dx_aluctr_d   = dx_aluctr_q;
    dx_shamt_d    = dx_shamt_q;
    dx_memtoreg_d = dx_memtoreg_q;
    dx_memwrite_d = dx_memwrite_q;
    dx_jump_d     = dx_jump_q;
    dx_br_d       = dx_br_q;
    dx_offset_d   = dx_offset_q;
    dx_addr_d     = dx_addr_q;
    dx_illegal_d  = dx_illegal_q;
    if (en) begin
      if (flush || stall || !fd_valid) begin
        dx_valid_d    = 1'b0;
        dx_rd_d       = '0;
        dx_memtoreg_d = 1'b0;
        dx_memwrite_d = 1'b0;
        dx_jump_d     = 1'b0;
        dx_br_d       = BR_NONE;
        dx_illegal_d  = 1'b0;
      end else begin
        dx_valid_d    = 1'b1;
        dx_a_d        = rs_val;
        dx_b_d        = dec_use_imm ? imm_sext : rt_val;
        dx_rt_d       = rt_val;
        dx_pc_d       = fd_pc;
        dx_rd_d       = dec_rd;
        dx_aluctr_d   = dec_aluctr;
        dx_shamt_d    = fd_ir[10:6];
        dx_memtoreg_d = dec_memtoreg;
        dx_memwrite_d = dec_memwrite;
        dx_jump_d     = dec_jump;
        dx_br_d       = dec_br;
        dx_offset_d   = imm_sext << 2;
        dx_addr_d     = {fd_ir[25:0], 2'b00};
        dx_illegal_d  = dec_illegal;
      end
    end
  end

  // DX pipeline register
  always_ff @(posedge clk) begin
    if (rst) begin
      dx_valid_q    <= 1'b0;
      dx_a_q        <= '0;
      dx_b_q        <= '0;
      dx_rt_q       <= '0;
      dx_pc_q       <= '0;
      dx_rd_q       <= '0;
      dx_aluctr_q   <= '0;
      dx_shamt_q    <= '0;
      dx_memtoreg_q <= 1'b0;
      dx_memwrite_q <= 1'b0;
      dx_jump_q     <= 1'b0;
      dx_br_q       <= '0;
      dx_offset_q   <= '0;
      dx_addr_q     <= '0;
      dx_illegal_q  <= 1'b0;
    end else begin
      dx_valid_q    <= dx_valid_d;
      dx_a_q        <= dx_a_d;
      dx_b_q        <= dx_b_d;
      dx_rt_q       <= dx_rt_d;
      dx_pc_q       <= dx_pc_d;
      dx_rd_q       <= dx_rd_d;
      dx_aluctr_q   <= dx_aluctr_d;
      dx_shamt_q    <= dx_shamt_d;
      dx_memtoreg_q <= dx_memtoreg_d;
      dx_memwrite_q <= dx_memwrite_d;
      dx_jump_q     <= dx_jump_d;
      dx_br_q       <= dx_br_d;
      dx_offset_q   <= dx_offset_d;
      dx_addr_q     <= dx_addr_d;
      dx_illegal_q  <= dx_illegal_d;
    end
  end

  assign dx_valid    = dx_valid_q;
  assign dx_a        = dx_a_q;
  assign dx_b        = dx_b_q;
  assign dx_rt       = dx_rt_q;
  assign dx_pc       = dx_pc_q;
  assign dx_rd       = dx_rd_q;
  assign dx_aluctr   = dx_aluctr_q;
  assign dx_shamt    = dx_shamt_q;
  assign dx_memtoreg = dx_memtoreg_q;
  assign dx_memwrite = dx_memwrite_q;
  assign dx_jump     = dx_jump_q;
  assign dx_br       = dx_br_q;
  assign dx_offset   = dx_offset_q;
  assign dx_addr     = dx_addr_q;
  assign dx_illegal  = dx_illegal_q;

endmodule
